// File: rtl/pool_window_driver.sv
// rtl/pool_window_driver.sv - 2x2 pooling window walker and start/finish initiator; optional watchdog under POOL_TIMEOUT_EN
module pool_window_driver #(
    parameter int N       = 28,
    parameter int DW      = 16,
    parameter int AW      = 10,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] win00,
    output logic [DW-1:0] win01,
    output logic [DW-1:0] win10,
    output logic [DW-1:0] win11,
    output logic          pool_start,
    input  logic          pool_finish,
    input  logic [DW-1:0] pool_pixel,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
`ifdef POOL_TIMEOUT_EN
    ,
    output logic          err
`endif
);
    localparam int M = N / 2;
    localparam logic [AW-1:0] NA = AW'(N);
    localparam logic [AW-1:0] MA = AW'(M);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPT, S_REQ, S_WRITE, S_RELEASE, S_DONE
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] r, c;
    logic [1:0]    phase;
    logic          armed;
    logic          tmo;
    logic          last_win;
    logic [AW-1:0] row, col;

    assign last_win = (r == MA - 1'b1) && (c == MA - 1'b1);
    // Tap row/col inside the current 2x2 window: phase[1] picks the row, phase[0] the column
    assign row = {r[AW-2:0], phase[1]};
    assign col = {c[AW-2:0], phase[0]};

`ifdef POOL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;
    logic          err_q;

    // Cycle counter for the two handshake waits, restarted on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state_next != state)
            cnt <= '0;
        else if ((state == S_REQ) || (state == S_RELEASE))
            cnt <= cnt + 1'b1;
    end

    assign tmo = ((state == S_REQ) || (state == S_RELEASE)) && (cnt == TW'(TIMEOUT - 1));

    // Sticky timeout flag, cleared by reset or by the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if ((state == S_IDLE) && start)
            err_q <= 1'b0;
        else if (tmo)
            err_q <= 1'b1;
    end

    assign err = err_q | tmo;
`else
    // Watchdog compiled out: the timeout condition can never fire
    assign tmo = (TIMEOUT < 0);
`endif

    // State register; reset drops every strobe and pool_start immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic and the state-decoded strobes
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        rd_en      = 1'b0;
        pool_start = 1'b0;
        wr_en      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_next = (M == 0) ? S_DONE : S_READ;
            end
            S_READ: begin
                rd_en = 1'b1;
                if (phase == 2'd3)
                    state_next = S_CAPT;
            end
            S_CAPT: state_next = S_REQ;
            S_REQ: begin
                pool_start = !tmo;
                if (tmo)
                    state_next = S_IDLE;
                else if (pool_finish && armed)
                    state_next = S_WRITE;
            end
            S_WRITE: begin
                pool_start = 1'b1;
                wr_en      = 1'b1;
                state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (tmo)
                    state_next = S_IDLE;
                else if (!pool_finish)
                    state_next = last_win ? S_DONE : S_READ;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Input RAM address for the current window tap, zero outside READ
    always_comb begin
        rd_addr = '0;
        if (state == S_READ)
            rd_addr = row * NA + col;
    end

    // Window position, tap capture, stale-finish guard and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= '0;
            c       <= '0;
            phase   <= '0;
            armed   <= 1'b0;
            win00   <= '0;
            win01   <= '0;
            win10   <= '0;
            win11   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r     <= '0;
                        c     <= '0;
                        phase <= '0;
                        win00 <= '0;
                        win01 <= '0;
                        win10 <= '0;
                        win11 <= '0;
                    end
                end
                S_READ: begin
                    phase <= phase + 2'd1;
                    case (phase)
                        2'd1:    win00 <= rd_data;
                        2'd2:    win01 <= rd_data;
                        2'd3:    win10 <= rd_data;
                        default: ;
                    endcase
                end
                S_CAPT: begin
                    win11 <= rd_data;
                    // A finish already high before the request is left over from the slave
                    armed <= !pool_finish;
                end
                S_REQ: begin
                    if (!pool_finish)
                        armed <= 1'b1;
                    else if (armed && !tmo) begin
                        wr_data <= pool_pixel;
                        wr_addr <= r * MA + c;
                    end
                end
                S_RELEASE: begin
                    if (!pool_finish && !tmo) begin
                        if (c == MA - 1'b1) begin
                            c <= '0;
                            r <= r + 1'b1;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
